// File: rtl/ntt_bf_post.sv
// Butterfly back-end after mo_mul: delays u/inv to meet the Montgomery product,
// then forms (u+t, u-t) mod Q with optional INTT halving and a per-stage last flag.
package ntt_pkg;
   parameter int DATA_WIDTH = 23;
   parameter int Q_K = 23;
   parameter int Q = 8380417;
endpackage

module ntt_bf_post #(
   parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
   parameter int MUL_LAT = DATA_WIDTH + 2,
   parameter int N_BF = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] u_in,
   input  logic                  inv_in,
   input  logic [DATA_WIDTH-1:0] prod,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic                  out_last
);

   localparam logic [DATA_WIDTH:0] QX = (DATA_WIDTH+1)'(ntt_pkg::Q);
   localparam logic [DATA_WIDTH-1:0] QD = DATA_WIDTH'(ntt_pkg::Q);
   localparam int CW = (N_BF > 1) ? $clog2(N_BF) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(N_BF - 1);

   generate
      if (MUL_LAT < 1) begin : g_bad_lat
         $error("ntt_bf_post: MUL_LAT must be >= 1");
      end
      if (N_BF < 1) begin : g_bad_nbf
         $error("ntt_bf_post: N_BF must be >= 1");
      end
   endgenerate

   logic [MUL_LAT-1:0]    vld_sr;
   logic [MUL_LAT-1:0]    inv_sr;
   logic [DATA_WIDTH-1:0] u_sr [MUL_LAT];

   logic                  tap_v;
   logic                  tap_inv;
   logic [DATA_WIDTH-1:0] tap_u;

   logic [DATA_WIDTH-1:0] t;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH:0]   dif;
   logic [DATA_WIDTH-1:0] s_n;
   logic [DATA_WIDTH-1:0] d_n;

   logic                  s1_v;
   logic                  s1_inv;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;
   logic [DATA_WIDTH-1:0] a_h;
   logic [DATA_WIDTH-1:0] b_h;

   logic [CW-1:0]         cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= in_valid;
         for (int i = 1; i < MUL_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      end
   end

   // payload is don't-care while its valid bit is low, so no reset
   always_ff @(posedge clk) begin
      inv_sr[0] <= inv_in;
      u_sr[0]   <= u_in;
      for (int i = 1; i < MUL_LAT; i++) begin
         inv_sr[i] <= inv_sr[i-1];
         u_sr[i]   <= u_sr[i-1];
      end
   end

   assign tap_v   = vld_sr[MUL_LAT-1];
   assign tap_inv = inv_sr[MUL_LAT-1];
   assign tap_u   = u_sr[MUL_LAT-1];

   // mo_mul may return Q itself, which is congruent to 0
   always_comb begin
      t   = (prod == QD) ? '0 : prod;
      sum = {1'b0, tap_u} + {1'b0, t};
      dif = {1'b0, tap_u} - {1'b0, t};
      s_n = (sum >= QX) ? DATA_WIDTH'(sum - QX) : DATA_WIDTH'(sum);
      d_n = dif[DATA_WIDTH] ? DATA_WIDTH'(dif + QX) : DATA_WIDTH'(dif);
   end

   always_ff @(posedge clk) begin
      if (rst) s1_v <= 1'b0;
      else     s1_v <= tap_v;
   end

   always_ff @(posedge clk) begin
      if (tap_v) begin
         s1_a   <= s_n;
         s1_b   <= d_n;
         s1_inv <= tap_inv;
      end
   end

   // odd x: x+Q is even, so the shift is an exact division by 2 mod Q
   always_comb begin
      a_h = DATA_WIDTH'(({1'b0, s1_a} + (s1_a[0] ? QX : '0)) >> 1);
      b_h = DATA_WIDTH'(({1'b0, s1_b} + (s1_b[0] ? QX : '0)) >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         cnt       <= '0;
      end else begin
         out_valid <= s1_v;
         out_last  <= s1_v && (cnt == CNT_MAX);
         if (s1_v) begin
            out_a <= s1_inv ? a_h : s1_a;
            out_b <= s1_inv ? b_h : s1_b;
            cnt   <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ntt_bf_post.sv
// Self-checking bench for ntt_bf_post: modular reference model with queue
// scoreboard, latency tracking, out_last positions and reset flush.
module tb_ntt_bf_post;

   localparam int DW  = 23;
   localparam int LAT = DW + 2;
   localparam int NB  = 128;
   localparam int Q   = 8380417;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] u_in;
   logic          inv_in;
   logic [DW-1:0] prod;
   logic          out_valid;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic          out_last;

   always #5 clk = ~clk;

   ntt_bf_post #(
      .DATA_WIDTH(DW),
      .MUL_LAT(LAT),
      .N_BF(NB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .u_in(u_in),
      .inv_in(inv_in),
      .prod(prod),
      .out_valid(out_valid),
      .out_a(out_a),
      .out_b(out_b),
      .out_last(out_last)
   );

   typedef struct {
      int due;
      int a;
      int b;
   } exp_t;

   exp_t q[$];
   int   prod_at[int];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   nout = 0;
   int   nlast = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // reference: plain modular arithmetic, halving as multiply by 2^-1 mod Q
   function automatic void model(input int u, input int p, input bit inv,
                                 output int a, output int b);
      longint t, x, y;
      t = (p == Q) ? 0 : p;
      x = (longint'(u) + t) % Q;
      y = (longint'(u) - t + Q) % Q;
      if (inv) begin
         x = (x * ((Q + 1) / 2)) % Q;
         y = (y * ((Q + 1) / 2)) % Q;
      end
      a = int'(x);
      b = int'(y);
   endfunction

   // product arrives LAT cycles after issue; otherwise random junk
   always @(negedge clk) begin
      if (prod_at.exists(cyc)) prod = DW'(prod_at[cyc]);
      else                     prod = DW'($urandom);
   end

   always @(posedge clk) begin
      bit   rs;
      exp_t e;
      rs = rst;
      cyc++;
      #1;
      if (rs) begin
         q.delete();
         nout = 0;
         chk("valid_after_rst", out_valid, 0);
      end else if (out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_last", out_last, (nout % NB) == NB - 1);
         end
         if (out_last) nlast++;
         nout++;
      end else begin
         chk("last_idle", out_last, 0);
         if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_valid", 0, 1);
            e = q.pop_front();
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input int u, input int p, input bit inv);
      int a, b;
      in_valid = 1'b1;
      u_in     = DW'(u);
      inv_in   = inv;
      prod_at[cyc + LAT] = p;
      if (!rst) begin
         model(u, p, inv, a, b);
         q.push_back('{cyc + LAT + 2, a, b});
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic directed(input string nm, input int u, input int p,
                           input bit inv, input int ea, input int eb);
      issue(u, p, inv);
      idle(LAT + 3);
      chk({nm, "_a"}, out_a, ea);
      chk({nm, "_b"}, out_b, eb);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() > 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", q.size(), 0);
      idle(2);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, b;
      rst      = 1'b1;
      in_valid = 1'b0;
      u_in     = '0;
      inv_in   = 1'b0;
      idle(3);
      chk("rst_valid", out_valid, 0);
      chk("rst_a", out_a, 0);
      chk("rst_b", out_b, 0);
      chk("rst_last", out_last, 0);
      rst = 1'b0;
      idle(2);

      model(5, 2, 1, a, b);
      chk("model_inv_a", a, 4190212);
      chk("model_inv_b", b, 4190210);
      model(3, 5, 0, a, b);
      chk("model_fwd_b", b, 8380415);
      model(7, Q, 0, a, b);
      chk("model_q_a", a, 7);

      directed("fwd0", 5, 3, 0, 8, 2);
      directed("fwd1", 3, 5, 0, 8, 8380415);
      directed("wrap", Q - 1, Q - 1, 0, 8380415, 0);
      directed("prodq", 7, Q, 0, 7, 7);
      directed("inv_odd", 5, 2, 1, 4190212, 4190210);
      directed("inv_even", 6, 2, 1, 4, 2);
      drain();

      for (int i = 0; i < 300; i++)
         issue($urandom_range(0, Q - 1), $urandom_range(0, Q), i[0]);
      drain();

      pulse_rst();
      idle(2);
      nlast = 0;
      for (int i = 0; i < 256; i++) begin
         issue($urandom_range(0, Q - 1), $urandom_range(0, Q),
               bit'($urandom_range(0, 1)));
         idle($urandom_range(0, 3));
      end
      drain();
      chk("nlast_256", nlast, 2);

      pulse_rst();
      idle(2);
      nlast = 0;
      for (int i = 0; i < 10; i++)
         issue($urandom_range(0, Q - 1), $urandom_range(0, Q), i[0]);
      rst = 1'b1;
      issue(1, 1, 0);
      rst = 1'b0;
      for (int i = 0; i < 128; i++)
         issue($urandom_range(0, Q - 1), $urandom_range(0, Q), i[0]);
      drain();
      chk("nlast_post_rst", nlast, 1);
      chk("nout_post_rst", nout, 128);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ntt_bf_post.md
Name: ntt_bf_post

Overview:
- Butterfly back-end stage that sits directly downstream of mo_mul in the NTT/INTT datapath.
- It holds the butterfly "u" operand and a mode bit in a delay line for the multiplier's fixed latency.
- When the Montgomery product t = w*b*2^-DATA_WIDTH mod Q arrives, it forms u+t and u-t mod Q, optionally halves both (INTT scaling), and emits them with a valid flag and a per-stage last marker.
- Free-running pipeline, no backpressure, matching mo_mul.

Parameters:
- DATA_WIDTH, ntt_pkg DATA_WIDTH (23): coefficient width. Q, Q_M and Q_K come from ntt_pkg.
- MUL_LAT, DATA_WIDTH+2: cycles from mo_mul operand presentation to mo_mul result. It must equal the instantiated mo_mul latency.
- N_BF, 128: butterflies per NTT stage; sets the out_last period.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  butterfly issued this cycle; same cycle as the mo_mul a/b operands
- u_in  in  DATA_WIDTH  u operand, range 0..Q-1
- inv_in  in  1  0 = forward (no scaling), 1 = inverse (halve outputs mod Q)
- prod  in  DATA_WIDTH  mo_mul result, range 0..Q inclusive, valid MUL_LAT cycles after issue
- out_valid  out  1  outputs valid
- out_a  out  DATA_WIDTH  (u+t) mod Q, halved if inv; range 0..Q-1
- out_b  out  DATA_WIDTH  (u-t) mod Q, halved if inv; range 0..Q-1
- out_last  out  1  high with the N_BF-th valid output of each stage

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_a=0, out_b=0, out_last=0, output counter=0, all valid delay-line bits=0.
- u/inv delay-line data is not reset; it is don't-care while its valid bit is 0.
- Delay line:
  - {in_valid, inv_in, u_in} shift through MUL_LAT registers every cycle.
  - The tap at depth MUL_LAT is aligned with prod.
  - Registered shift register; a counter-addressed RAM is allowed if it is cycle-equivalent.
- Stage 1, registered:
  - t' = (prod==Q) ? 0 : prod.
  - s = u + t'. If s >= Q, subtract Q. Carry width DATA_WIDTH+1.
  - d = u - t'. If negative, add Q. Signed DATA_WIDTH+1.
  - Register s, d, inv and valid.
- Stage 2, registered:
  - If inv: x/2 when x is even, else (x+Q)/2 (Q is odd, so the sum is even; DATA_WIDTH+1-bit add).
  - If not inv: pass through.
  - Drive out_a/out_b/out_valid.
- Total latency: in_valid at cycle n gives out_valid at cycle n+MUL_LAT+2. Latency is identical for both modes.
- When out_valid=0, out_a/out_b hold their last values; only out_valid and out_last are qualified.
- Counter:
  - Increments on each out_valid.
  - out_last = out_valid && counter==N_BF-1, combinationally registered with the outputs.
  - Counter wraps to 0 after N_BF-1.
  - Gaps in valid do not advance or clear it.
- inv is carried per beat. Mode may change on any cycle, including back-to-back beats, without bubbles.
- Reset mid-operation:
  - All in-flight beats are dropped; out_valid=0 from the cycle after rst is sampled until new issues propagate.
  - Counter restarts at 0.
  - Beats issued while rst=1 are discarded.
- prod is ignored when the aligned valid bit is 0.
- Elaboration $error if MUL_LAT<1 or N_BF<1.

Test Plan (Q=8380417, DATA_WIDTH=23):
- Forward basics:
  - u=5, prod=3, inv=0 → out_a=5+3=8, out_b=5-3=2, out_valid exactly MUL_LAT+2 cycles after issue.
  - u=3, prod=5 → out_a=8, out_b=3-5+Q=8380415.
- Wrap and edge range:
  - u=Q-1, prod=Q-1 → out_a=8380415, out_b=0.
  - u=7, prod=Q (=8380417) → t' treated as 0, so out_a=7, out_b=7.
- Inverse halving:
  - u=5, prod=2, inv=1 → a=7, odd, so (7+Q)/2: out_a=4190212.
  - Same beat: b=3, odd, so (3+Q)/2: out_b=4190210.
  - u=6, prod=2, inv=1 → out_a=4, out_b=2.
- Streaming and mode interleave:
  - 300 back-to-back random beats alternating inv → every output matches a reference model in order.
  - No bubbles on the mode change.
- out_last:
  - 256 valid beats with random 0-3 cycle gaps → out_last high only on the 128th and 256th outputs.
- Reset mid-burst:
  - Assert rst for 1 cycle while 10 beats are in flight → no out_valid for those beats.
  - Then issue 128 beats → out_last on the 128th post-reset output.
